mdr_mem_unit: RTL
=================

// Module: mdr_mem_unit
// PURPOSE
//  Memory Data Register plus memory read/write handshake engine. Loads from the CPU bus mux output or from memory read data.
//  mdr_out feeds the bus mux MDR input (source select 5'd21).
//  Runs single-word req/ack transactions to the memory so control sequencing only issues start pulses and waits for done.
// PARAMETERS
//  DATA_W   32  data width of bus, MDR and memory data
//  ADDR_W   9   memory word address width (512 words)
//  TIMEOUT  15  cycles without mem_ack before abort (only with MDR_TIMEOUT_EN)
// PORTS
//  clock        in   1       single clock, rising edge
//  clear_n      in   1       asynchronous, active-low reset
//  bus_in       in   DATA_W  bus mux output (BusMux_Out)
//  mdr_in       in   1       load MDR from bus_in (IDLE only)
//  addr_in      in   ADDR_W  transaction address, latched at start
//  start_rd     in   1       start memory read into MDR (1-cycle pulse)
//  start_wr     in   1       start memory write of MDR (1-cycle pulse)
//  err_clr      in   1       clear sticky timeout_err
//  mdr_out      out  DATA_W  MDR contents to bus mux
//  busy         out  1       transaction in progress
//  done         out  1       1-cycle pulse on transaction completion
//  timeout_err  out  1       sticky: transaction aborted on timeout
//  mem_req      out  1       memory request, held until ack or abort
//  mem_we       out  1       1=write, 0=read; valid while mem_req
//  mem_addr     out  ADDR_W  latched address
//  mem_wdata    out  DATA_W  write data (= MDR)
//  mem_ack      in   1       memory ack, 1 cycle, data valid with it
//  mem_rdata    in   DATA_W  read data, sampled when mem_ack
// BEHAVIOUR
//  - Reset (clear_n=0, async): state IDLE; mdr_out, mem_addr = 0.
//    mem_req, mem_we, busy, done, timeout_err = 0; timeout counter = 0.
//  - All outputs are registered. mem_wdata is wired to mdr_out.
//  - States: IDLE, RD_WAIT, WR_WAIT.
//  - IDLE + start_rd at edge N: mem_addr<=addr_in, mem_we<=0, mem_req<=1, busy<=1, go RD_WAIT.
//  - IDLE + start_wr at edge N: same with mem_we<=1, go WR_WAIT.
//  - start_rd and start_wr together: read wins; write is dropped.
//  - mdr_in in IDLE loads bus_in next edge. If it coincides with start_wr, the new bus_in value is both loaded and written.
//  - RD_WAIT + mem_ack at edge M: mdr_out<=mem_rdata; mem_req, busy <= 0; done<=1 (cycle M+1 only); go IDLE.
//  - WR_WAIT + mem_ack: same, except the MDR is unchanged.
//  - Latency with zero-wait memory (ack the cycle after req rises): start -> done = 2 cycles.
//  - While busy: mdr_in, start_rd and start_wr are ignored; MDR is frozen.
//  - mem_ack while mem_req=0 is ignored.
//  - Reset mid-transaction: mem_req drops immediately (async); the transaction is lost and no done is issued.
//  - err_clr clears timeout_err next edge; a simultaneous new timeout wins (flag stays 1).
// CONFIGURATION
//  MDR_TIMEOUT_EN defined:
//    - A counter runs in RD_WAIT/WR_WAIT, reset at each start.
//    - Reaching TIMEOUT cycles without ack: mem_req<=0, busy<=0, timeout_err<=1, go IDLE. No done; MDR is unchanged.
//    - Ack in the same cycle the counter hits TIMEOUT counts as success.
//  MDR_TIMEOUT_EN undefined: no counter; the unit waits indefinitely; timeout_err is tied 0.
// STRUCTURE
//  - Package mdr_pkg: DATA_W/ADDR_W defaults, mdr_state_t enum (IDLE, RD_WAIT, WR_WAIT), timeout counter width constant.
//  - Sub-module mdr_reg: DATA_W register with 2:1 input mux (bus_in vs mem_rdata), load enable, async active-low clear.
//  - FSM, address latch and timeout logic live in mdr_mem_unit.
// TESTING
//  - Reset: clear_n=0 mid-RD_WAIT -> mem_req, busy, mdr_out = 0 before the next edge; no done.
//  - Bus load: bus_in=32'hDEADBEEF, mdr_in=1 -> mdr_out=DEADBEEF next cycle.
//  - Read: start_rd, addr_in=9'h05, mem_rdata=32'h12345678, ack 3 cycles after req -> mem_addr=05, mem_we=0, mdr_out=12345678, done 1 cycle.
//  - Write: MDR=32'hA5A5A5A5, start_wr, addr_in=9'h1FF, ack 1 cycle after req -> mem_we=1, mem_wdata=A5A5A5A5, done, MDR unchanged.
//  - Collisions: start_rd+start_wr together -> read performed; mdr_in/start_wr while busy -> MDR and transaction unaffected.
//  - Timeout (MDR_TIMEOUT_EN, TIMEOUT=15): no ack -> mem_req drops after 15 cycles, timeout_err=1, no done; err_clr -> 0.

Source files
------------

// File: rtl/mdr_pkg.sv
// Shared constants and types for the memory data register unit.
package mdr_pkg;

  localparam int MDR_DATA_W   = 32;
  localparam int MDR_ADDR_W   = 9;
  localparam int MDR_TIMEOUT  = 15;
  localparam int MDR_TO_CNT_W = $clog2(MDR_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } mdr_state_t;

endpackage

// File: rtl/mdr_reg.sv
// Memory data register: a single word selected from the CPU bus or memory read data.
module mdr_reg
  import mdr_pkg::*;
#(
  parameter int DATA_W = MDR_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic              sel_mem_i,
  input  logic [DATA_W-1:0] bus_i,
  input  logic [DATA_W-1:0] mem_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) q_d = sel_mem_i ? mem_i : bus_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) q_q <= '0;
    else          q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/mdr_mem_unit.sv
// MDR plus single-word req/ack memory handshake engine.
// Define MDR_TIMEOUT_EN to abort transactions that see no ack within TIMEOUT cycles.
module mdr_mem_unit
  import mdr_pkg::*;
#(
  parameter int DATA_W  = MDR_DATA_W,
  parameter int ADDR_W  = MDR_ADDR_W
`ifdef MDR_TIMEOUT_EN
  ,
  parameter int TIMEOUT = MDR_TIMEOUT
`endif
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mdr_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              start_rd,
  input  logic              start_wr,
  input  logic              err_clr,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  mdr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              terr_q, terr_d;
  logic              mdr_load, mdr_sel_mem;
  logic              timeout_hit;

`ifdef MDR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;

  // Counter sits at zero in IDLE, so every start begins a fresh count.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n)              cnt_q <= '0;
    else if (state_q == IDLE)  cnt_q <= '0;
    else                       cnt_q <= cnt_q + 1'b1;
  end

  assign timeout_hit = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    req_d       = req_q;
    we_d        = we_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    terr_d      = err_clr ? 1'b0 : terr_q;
    mdr_load    = 1'b0;
    mdr_sel_mem = 1'b0;
    case (state_q)
      IDLE: begin
        mdr_load = mdr_in;
        if (start_rd || start_wr) begin
          addr_d  = addr_in;
          we_d    = !start_rd;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = start_rd ? RD_WAIT : WR_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        // An ack on the last allowed cycle still counts as success.
        if (mem_ack) begin
          req_d       = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
          mdr_load    = (state_q == RD_WAIT);
          mdr_sel_mem = 1'b1;
        end else if (timeout_hit) begin
          req_d   = 1'b0;
          busy_d  = 1'b0;
          terr_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
    end
  end

  mdr_reg #(.DATA_W(DATA_W)) u_mdr (
    .clk_i    (clock),
    .rst_n_i  (clear_n),
    .load_i   (mdr_load),
    .sel_mem_i(mdr_sel_mem),
    .bus_i    (bus_in),
    .mem_i    (mem_rdata),
    .q_o      (mdr_out)
  );

  assign mem_wdata = mdr_out;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;
`ifdef MDR_TIMEOUT_EN
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
